// File: rtl/btb_write_ctrl.sv
// btb_write_ctrl: filters EX branch reports into a FIFO drained 1/cycle to the BTB write port (wr_*), with a full-BTB invalidate sweep on flush_req (flush_busy); upd_ready = queue not full
module btb_write_ctrl #(
  parameter int BUFFER_ADDR_LEN = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd_valid,
  input  logic [31:0] upd_PC,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_hit,
  input  logic [31:0] upd_pred_PC,
  output logic        upd_ready,
  input  logic        flush_req,
  output logic        flush_busy,
  output logic        wr_req,
  output logic [31:0] wr_PC,
  output logic [31:0] wr_predicted_PC,
  output logic        wr_predicted_state_bit
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_nxt;
  logic [64:0] mem [FIFO_DEPTH];
  logic [64:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [BUFFER_ADDR_LEN-1:0] idx;
  logic full, want, start, last, push, pop;
  always_comb begin
    full = count == (AW+1)'(FIFO_DEPTH);
    want = upd_taken ? (!upd_hit || upd_pred_PC != upd_target) : upd_hit;
    start = state == IDLE && flush_req;
    last = idx == '1;
    push = upd_valid && !full && want && !start;
    pop = state == IDLE && count != '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE ? (flush_req ? FLUSH : IDLE) : (last ? IDLE : FLUSH);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      idx <= '0;
    end else if (start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      idx <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (state == FLUSH) idx <= idx + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {upd_PC, upd_taken ? upd_target : 32'h0, upd_taken};
  end
  always_comb begin
    head = mem[rd_ptr];
    upd_ready = !full;
    flush_busy = state == FLUSH;
    wr_req = flush_busy || pop;
    wr_PC = flush_busy ? {{(30-BUFFER_ADDR_LEN){1'b0}}, idx, 2'b00} : pop ? head[64:33] : '0;
    wr_predicted_PC = pop ? head[32:1] : '0;
    wr_predicted_state_bit = pop && head[0];
  end
endmodule

// File: tb/tb_btb_write_ctrl.sv
// tb_btb_write_ctrl: directed checks of filter, drain, sweep, flush discard and reset
module tb_btb_write_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic upd_valid = 1'b0, upd_taken = 1'b0, upd_hit = 1'b0, flush_req = 1'b0;
  logic [31:0] upd_PC = '0, upd_target = '0, upd_pred_PC = '0;
  logic upd_ready, flush_busy, wr_req, wr_predicted_state_bit;
  logic [31:0] wr_PC, wr_predicted_PC;
  logic [65:0] wr_all;
  int checks = 0, errors = 0;
  btb_write_ctrl #(.BUFFER_ADDR_LEN(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_PC(upd_PC), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_hit(upd_hit), .upd_pred_PC(upd_pred_PC), .upd_ready(upd_ready),
    .flush_req(flush_req), .flush_busy(flush_busy), .wr_req(wr_req), .wr_PC(wr_PC),
    .wr_predicted_PC(wr_predicted_PC), .wr_predicted_state_bit(wr_predicted_state_bit)
  );
  always #5 clk = ~clk;
  assign wr_all = {wr_req, wr_PC, wr_predicted_PC, wr_predicted_state_bit};
  task automatic chk(string tag, logic [65:0] obs, logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [65:0] wv(logic r, logic [31:0] pc, logic [31:0] t, logic s);
    return {r, pc, t, s};
  endfunction
  task automatic drive(logic v, logic [31:0] pc, logic tk, logic [31:0] tg, logic h, logic [31:0] pp);
    upd_valid = v;
    upd_PC = pc;
    upd_taken = tk;
    upd_target = tg;
    upd_hit = h;
    upd_pred_PC = pp;
  endtask
  task automatic nxt;
    @(negedge clk);
  endtask
  initial begin
    repeat (2) nxt();
    chk("rst_ready", upd_ready, 1);
    chk("rst_busy", flush_busy, 0);
    chk("rst_wr", wr_all, 0);
    rst_n = 1'b1;
    nxt();
    chk("rel_ready", upd_ready, 1);
    chk("rel_wr", wr_all, 0);
    drive(1, 32'h100, 1, 32'h200, 0, 0);
    nxt();
    chk("flt_miss", wr_all, wv(1, 32'h100, 32'h200, 1));
    drive(1, 32'h100, 1, 32'h200, 1, 32'h200);
    nxt();
    chk("flt_correct", wr_all, 0);
    drive(1, 32'h104, 0, 0, 1, 32'h300);
    nxt();
    chk("flt_nt_hit", wr_all, wv(1, 32'h104, 0, 0));
    drive(1, 32'h108, 0, 0, 0, 0);
    nxt();
    chk("flt_nt_miss", wr_all, 0);
    drive(1, 32'h10C, 1, 32'h300, 1, 32'h200);
    nxt();
    chk("flt_wrong_tgt", wr_all, wv(1, 32'h10C, 32'h300, 1));
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      nxt();
      chk("b2b_ready", upd_ready, 1);
      if (i > 0) chk("b2b_wr", wr_all, wv(1, 32'h10 + 32'(4 * (i - 1)), 32'h1000 + 32'(i - 1), 1));
      else chk("b2b_idle", wr_all, 0);
      drive(1, 32'h10 + 32'(4 * i), 1, 32'h1000 + 32'(i), 0, 0);
    end
    nxt();
    chk("b2b_last", wr_all, wv(1, 32'h24, 32'h1005, 1));
    drive(0, 0, 0, 0, 0, 0);
    nxt();
    chk("b2b_done", wr_all, 0);
    flush_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      nxt();
      flush_req = (k == 8 || k == 15);
      chk("sw1_busy", flush_busy, 1);
      chk("sw1_wr", wr_all, wv(1, 32'(4 * k), 0, 0));
    end
    nxt();
    flush_req = 1'b0;
    chk("sw1_end_busy", flush_busy, 0);
    chk("sw1_end_wr", wr_all, 0);
    nxt();
    chk("sw1_norestart", {flush_busy, wr_req}, 0);
    flush_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      nxt();
      flush_req = 1'b0;
      if (k <= 4) drive(1, 32'h40 + 32'(4 * k), 1, 32'h2000 + 32'(k), 0, 0);
      chk("sw2_ready", upd_ready, (k < 4) ? 1 : 0);
      chk("sw2_wr", wr_all, wv(1, 32'(4 * k), 0, 0));
    end
    nxt();
    chk("sw2_p0_ready", upd_ready, 0);
    chk("sw2_p0_busy", flush_busy, 0);
    chk("sw2_p0_wr", wr_all, wv(1, 32'h40, 32'h2000, 1));
    nxt();
    chk("sw2_p1_ready", upd_ready, 1);
    chk("sw2_p1_wr", wr_all, wv(1, 32'h44, 32'h2001, 1));
    nxt();
    drive(0, 0, 0, 0, 0, 0);
    chk("sw2_p2_wr", wr_all, wv(1, 32'h48, 32'h2002, 1));
    nxt();
    chk("sw2_p3_wr", wr_all, wv(1, 32'h4C, 32'h2003, 1));
    nxt();
    chk("sw2_p4_wr", wr_all, wv(1, 32'h50, 32'h2004, 1));
    nxt();
    chk("sw2_p5_wr", wr_all, 0);
    flush_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      nxt();
      flush_req = 1'b0;
      if (k <= 3) drive(1, 32'h80 + 32'(4 * k), 1, 32'h3000 + 32'(k), 0, 0);
      else drive(0, 0, 0, 0, 0, 0);
    end
    nxt();
    chk("sw3_p0_wr", wr_all, wv(1, 32'h80, 32'h3000, 1));
    nxt();
    drive(1, 32'h600, 1, 32'h4000, 0, 0);
    chk("sw3_p1_ready", upd_ready, 1);
    chk("sw3_p1_wr", wr_all, wv(1, 32'h84, 32'h3001, 1));
    nxt();
    drive(1, 32'h604, 1, 32'h4004, 0, 0);
    flush_req = 1'b1;
    chk("sw3_p2_ready", upd_ready, 1);
    chk("sw3_p2_wr", wr_all, wv(1, 32'h88, 32'h3002, 1));
    for (int k = 0; k < 16; k++) begin
      nxt();
      flush_req = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      chk("sw4_wr", wr_all, wv(1, 32'(4 * k), 0, 0));
    end
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk("discard_wr", wr_all, 0);
      chk("discard_busy", flush_busy, 0);
    end
    flush_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      nxt();
      flush_req = 1'b0;
      chk("sw5_wr", wr_all, wv(1, 32'(4 * k), 0, 0));
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr", wr_all, 0);
    chk("mid_rst_busy", flush_busy, 0);
    chk("mid_rst_ready", upd_ready, 1);
    nxt();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk("post_rst", {flush_busy, wr_req}, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/btb_write_ctrl.md
# btb_write_ctrl

Owns the single write port of the direct-mapped branch target buffer. Takes branch-resolution reports from the EX stage and keeps only the ones that change BTB contents. Queues those reports and drains them one per cycle into the BTB. On request (e.g. `fence.i`, context switch) it runs an invalidate sweep over every entry. The block sits between the EX-stage branch unit and the BTB `wr_*` ports.

## Interface
- `BUFFER_ADDR_LEN`, 12: BTB index width; must match the BTB instance; sweep length is 2^BUFFER_ADDR_LEN.
- `FIFO_DEPTH`, 4: pending-update queue depth; power of two, ≥2.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `upd_valid`  in  1  EX reports a resolved branch/jump this cycle.
- `upd_PC`  in  32  PC of the resolved instruction.
- `upd_taken`  in  1  instruction actually redirected.
- `upd_target`  in  32  actual target (valid when taken).
- `upd_hit`  in  1  BTB predicted this instruction at fetch (`rd_predicted` carried down the pipe).
- `upd_pred_PC`  in  32  predicted PC carried down the pipe.
- `upd_ready`  out  1  update accepted on `upd_valid && upd_ready`.
- `flush_req`  in  1  single-cycle request to invalidate the whole BTB.
- `flush_busy`  out  1  sweep in progress.
- `wr_req`  out  1  BTB write strobe.
- `wr_PC`  out  32  BTB write PC.
- `wr_predicted_PC`  out  32  BTB write target.
- `wr_predicted_state_bit`  out  1  BTB write valid/state bit.

## Operation
- Filter, applied at acceptance:
  - `taken && (!hit || pred_PC != target)` → enqueue {PC, target, 1}.
  - `!taken && hit` → enqueue {PC, 0, 0}.
  - Otherwise the update is accepted and dropped; no FIFO slot is consumed.
- `upd_ready = !fifo_full`, in both states. Updates accepted during a sweep are post-flush history; they are queued and applied after the sweep.
- States:
  - IDLE: if the FIFO is non-empty, `wr_*` = FIFO head, `wr_req`=1, and the head pops that cycle. The BTB write is never back-pressured, so drain rate is 1/cycle.
  - FLUSH: sweep counter `idx` 0→2^N−1, one per cycle. `wr_req`=1, `wr_PC`={zeros, idx, 2'b00}, `wr_predicted_PC`=0, `wr_predicted_state_bit`=0. The FIFO only fills, it does not drain.
- IDLE→FLUSH on `flush_req`. At that edge:
  - the FIFO is cleared;
  - an update accepted in the same cycle is discarded, since it is pre-flush history;
  - `idx`←0.
- FLUSH→IDLE on the edge ending the cycle with `idx`=2^N−1.
- `flush_req` while in FLUSH, including the last sweep cycle, is ignored and does not restart the sweep.
- `wr_*` are driven from registered state only (FIFO head / `idx` / state). No input-to-`wr_*` combinational path.
- When `wr_req`=0, `wr_PC`, `wr_predicted_PC` and `wr_predicted_state_bit` are all 0.

## Timing
- Reset: state IDLE, FIFO empty, `idx`=0.
- Output values during reset: `upd_ready`=1, `flush_busy`=0, `wr_req`=0, all `wr_*`=0.
- Reset mid-sweep aborts immediately to IDLE; pending entries are lost.
- Update latency:
  - update accepted in cycle t with FIFO empty → `wr_req` high in cycle t+1;
  - with k entries queued → t+1+k.
- Flush: `flush_req` in cycle t → `flush_busy`=1 and first sweep write (`idx`=0) in t+1. Last write is in t+2^N. `flush_busy`=0 in t+2^N+1, and queued updates start draining that same cycle.
- Simultaneous push and pop in IDLE with FIFO full: `upd_ready`=0 that cycle; no same-cycle pass-through when full.
- FIFO pointers wrap modulo FIFO_DEPTH; the occupancy counter is log2(FIFO_DEPTH)+1 bits wide.

## Test plan
All scenarios use BUFFER_ADDR_LEN=4 and FIFO_DEPTH=4.
- Reset: hold `rst_n`=0 mid-stream → all outputs at reset values. Release → `upd_ready`=1, `wr_req`=0.
- Filter: upd {PC=0x100, taken, target=0x200, hit=0} → `wr_req` next cycle with {0x100, 0x200, 1}.
  - {0x100, taken, 0x200, hit=1, pred=0x200} → no write.
  - {0x104, not taken, hit=1} → write {0x104, 0, 0}.
  - {0x108, not taken, hit=0} → no write.
- Back-to-back: 6 consecutive writing updates (PC=0x10,0x14,…) → 6 `wr_req` cycles in order, each one cycle after its acceptance; `upd_ready` stays 1.
- Flush: pulse `flush_req` → exactly 16 `wr_req` cycles, `wr_PC`=0x00,0x04,…,0x3C, all state 0. `flush_busy` high for exactly those 16 cycles. A second `flush_req` at sweep cycle 8 is ignored.
- During the sweep, 5 writing updates are offered → first 4 accepted, `upd_ready`=0 for the 5th until the sweep ends. The 4 queued updates are written in the 4 cycles after the sweep, with `upd_ready` reasserting as slots free.
- A writing update queued the cycle before `flush_req`, plus one accepted in the `flush_req` cycle → neither is ever written.
- Assert `rst_n` low at sweep `idx`=5 → `wr_req`=0 immediately. After release the controller is in IDLE and does not resume the sweep.
